// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM geometry, channel mapping and arbiter source encoding.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: none.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W   = 12;
  localparam int VRAM_DATA_W   = 24;
  localparam int VRAM_CHANNELS = 3;
  localparam int CH_W          = 8;
  localparam int WAIT_W        = 8;

  // Byte-enable bit i covers word bits [BE_CH_LSB[i*5 +: 5] +: CH_W]
  localparam logic [VRAM_CHANNELS*5-1:0] BE_CH_LSB = {5'd16, 5'd8, 5'd0};

  // Owner of the memory port in a given cycle
  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_SCAN = 2'd1,
    SRC_WR0  = 2'd2,
    SRC_WR1  = 2'd3
  } src_e;

  // Expand channel enables into a per-bit write mask
  function automatic logic [VRAM_DATA_W-1:0] be_to_mask(input logic [VRAM_CHANNELS-1:0] be);
    logic [VRAM_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < VRAM_CHANNELS; i++) begin
      if (be[i]) begin
        mask[BE_CH_LSB[i*5 +: 5] +: CH_W] = {CH_W{1'b1}};
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: scan-out, two write ports, memory port and starvation status.
// Latency: none (wiring only).
// Backpressure: writers hold req until ack; scan requests are never stalled.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic                     scan_req;
  logic [ADDR_W-1:0]        scan_addr;
  logic                     scan_valid;
  logic [DATA_W-1:0]        scan_data;

  logic                     wr0_req;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic [VRAM_CHANNELS-1:0] wr0_be;
  logic                     wr0_ack;

  logic                     wr1_req;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic [VRAM_CHANNELS-1:0] wr1_be;
  logic                     wr1_ack;

  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [VRAM_CHANNELS-1:0] mem_be;
  logic [DATA_W-1:0]        mem_rdata;

  logic                     starve;
  logic                     starve_clr;

  // Arbiter side
  modport slave (
    input  scan_req, scan_addr,
    input  wr0_req, wr0_addr, wr0_data, wr0_be,
    input  wr1_req, wr1_addr, wr1_data, wr1_be,
    input  mem_rdata, starve_clr,
    output scan_valid, scan_data, wr0_ack, wr1_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, starve
  );

  // Requesters and memory side
  modport master (
    output scan_req, scan_addr,
    output wr0_req, wr0_addr, wr0_data, wr0_be,
    output wr1_req, wr1_addr, wr1_data, wr1_be,
    output mem_rdata, starve_clr,
    input  scan_valid, scan_data, wr0_ack, wr1_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, starve
  );

endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant; pointer remembers the last port granted.
// Latency: grant is combinational in the request cycle; pointer updates on the next edge.
// Backpressure: en=0 withholds all grants and freezes the pointer.
module rr_arb2
  import vram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 = port 0 granted last, 1 = port 1; resets to 1 so port 0 wins the first tie
  logic last;

  // Grant the lone requester, or on a tie the port that was not granted last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves only when a grant is actually issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between scan-out reads and two write ports.
// Latency: write ack combinational in the grant cycle; scan_data one cycle after grant.
// Backpressure: scan always wins; writers hold until ack, long waits raise sticky starve.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 255
) (
  input logic           CLK,
  input logic           RST,
  vram_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic              scan_gnt;
  logic              wr_en;
  logic [1:0]        wr_gnt;
  src_e              src;
  logic              rd_valid;
  logic              starve_q;
  logic              starve_set;
  logic [WAIT_W-1:0] wait0;
  logic [WAIT_W-1:0] wait1;
  logic [WAIT_W-1:0] wait0_nxt;
  logic [WAIT_W-1:0] wait1_nxt;

  // Nothing is granted while reset is held, so an un-acked write stays pending
  // at its requester and is arbitrated normally once reset is released.
  assign scan_gnt = bus.scan_req && !RST;
  assign wr_en    = !bus.scan_req && !RST;

  rr_arb2 u_rr (
    .clk (CLK),
    .rst (RST),
    .en  (wr_en),
    .req ({bus.wr1_req, bus.wr0_req}),
    .gnt (wr_gnt)
  );

  // Pick the single owner of the memory port this cycle
  always_comb begin
    src = SRC_IDLE;
    if (scan_gnt) begin
      src = SRC_SCAN;
    end else if (wr_gnt[0]) begin
      src = SRC_WR0;
    end else if (wr_gnt[1]) begin
      src = SRC_WR1;
    end
  end

  // Steer the owner onto the memory port; an idle port drives all zeros
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    case (src)
      SRC_SCAN: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.scan_addr;
      end
      SRC_WR0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.wr0_addr;
        bus.mem_wdata = bus.wr0_data;
        bus.mem_be    = bus.wr0_be;
      end
      SRC_WR1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.wr1_addr;
        bus.mem_wdata = bus.wr1_data;
        bus.mem_be    = bus.wr1_be;
      end
      default: ;
    endcase
  end

  assign bus.wr0_ack = wr_gnt[0];
  assign bus.wr1_ack = wr_gnt[1];

  // Read data is returned exactly as the memory presents it; no write forwarding
  assign bus.scan_valid = rd_valid;
  assign bus.scan_data  = rd_valid ? bus.mem_rdata : '0;

  // Track a granted scan read into the memory's one-cycle read latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= scan_gnt;
    end
  end

  // Saturating wait count: grows while requesting un-acked, clears on ack or idle
  function automatic logic [WAIT_W-1:0] wait_next(input logic req, input logic ack,
                                                  input logic [WAIT_W-1:0] cur);
    if (!req || ack) begin
      return '0;
    end
    if (&cur) begin
      return cur;
    end
    return cur + 1'b1;
  endfunction

  assign wait0_nxt  = wait_next(bus.wr0_req, wr_gnt[0], wait0);
  assign wait1_nxt  = wait_next(bus.wr1_req, wr_gnt[1], wait1);
  // Evaluated on the next count so starve rises on the edge the limit is reached
  assign starve_set = (wait0_nxt >= LIMIT) || (wait1_nxt >= LIMIT);

  // Per-writer wait counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait0 <= '0;
      wait1 <= '0;
    end else begin
      wait0 <= wait0_nxt;
      wait1 <= wait1_nxt;
    end
  end

  // Sticky starvation flag; a new set beats a simultaneous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q <= 1'b0;
    end else if (starve_set) begin
      starve_q <= 1'b1;
    end else if (bus.starve_clr) begin
      starve_q <= 1'b0;
    end
  end

  assign bus.starve = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with an expected-access scoreboard.
// Stimulus pushes expected memory accesses and read data; a negedge monitor pops and compares.
// A small synchronous-read memory model with channel enables answers the DUT.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [23:0] wdata;
    logic [2:0]  be;
    logic [1:0]  ack;   // {wr1_ack, wr0_ack}
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vram_arbiter_if #(.ADDR_W(12), .DATA_W(24)) bus ();

  vram_arbiter #(
    .ADDR_W       (12),
    .DATA_W       (24),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  acc_t        exp_acc[$];
  logic [23:0] exp_rd[$];
  logic        exp_starve = 1'b0;
  logic        done       = 1'b0;
  int          tests      = 0;
  int          fails      = 0;

  logic [23:0] mem [4096];

  // Memory model: synchronous read, per-channel masked write
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int c = 0; c < 3; c++) begin
          if (bus.mem_be[c]) mem[bus.mem_addr][8*c +: 8] <= bus.mem_wdata[8*c +: 8];
        end
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_scan(input logic [11:0] a);
    bus.scan_req  = 1'b1;
    bus.scan_addr = a;
  endtask

  task automatic set_wr0(input logic [11:0] a, input logic [23:0] d, input logic [2:0] be);
    bus.wr0_req  = 1'b1;
    bus.wr0_addr = a;
    bus.wr0_data = d;
    bus.wr0_be   = be;
  endtask

  task automatic set_wr1(input logic [11:0] a, input logic [23:0] d, input logic [2:0] be);
    bus.wr1_req  = 1'b1;
    bus.wr1_addr = a;
    bus.wr1_data = d;
    bus.wr1_be   = be;
  endtask

  task automatic push_wr(input bit port, input logic [11:0] a, input logic [23:0] d,
                         input logic [2:0] be);
    acc_t e;
    e.we    = 1'b1;
    e.addr  = a;
    e.wdata = d;
    e.be    = be;
    e.ack   = port ? 2'b10 : 2'b01;
    exp_acc.push_back(e);
  endtask

  task automatic push_scan(input logic [11:0] a, input bit has_data, input logic [23:0] d);
    acc_t e;
    e.we    = 1'b0;
    e.addr  = a;
    e.wdata = '0;
    e.be    = '0;
    e.ack   = 2'b00;
    exp_acc.push_back(e);
    if (has_data) exp_rd.push_back(d);
  endtask

  // Stimulus
  initial begin
    bus.scan_req   = 1'b0; bus.scan_addr = '0;
    bus.wr0_req    = 1'b0; bus.wr0_addr  = '0; bus.wr0_data = '0; bus.wr0_be = '0;
    bus.wr1_req    = 1'b0; bus.wr1_addr  = '0; bus.wr1_data = '0; bus.wr1_be = '0;
    bus.starve_clr = 1'b0;
    #1 rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Tie after reset: port 0 first, then port 1
    set_wr0(12'h010, 24'h0A0B0C, 3'b111);
    set_wr1(12'h020, 24'h123456, 3'b111);
    push_wr(0, 12'h010, 24'h0A0B0C, 3'b111);
    push_wr(1, 12'h020, 24'h123456, 3'b111);
    cyc(); bus.wr0_req = 1'b0;
    cyc(); bus.wr1_req = 1'b0;
    cyc();

    // Scan held 10 cycles with wr0 pending; wr0 waits long enough to starve
    set_wr0(12'h050, 24'h5A5A5A, 3'b011);
    for (int i = 0; i < 10; i++) begin
      set_scan(i[0] ? 12'h020 : 12'h010);
      push_scan(i[0] ? 12'h020 : 12'h010, 1, i[0] ? 24'h123456 : 24'h0A0B0C);
      cyc();
      exp_starve = (i >= 3);
    end
    bus.scan_req = 1'b0;
    push_wr(0, 12'h050, 24'h5A5A5A, 3'b011);
    cyc(); bus.wr0_req = 1'b0;
    cyc(); bus.starve_clr = 1'b1;
    cyc(); bus.starve_clr = 1'b0; exp_starve = 1'b0;

    // Tie straight after a scan cycle: pointer is 0, so port 1 wins
    set_scan(12'h020);
    push_scan(12'h020, 1, 24'h123456);
    set_wr0(12'h060, 24'h010203, 3'b111);
    set_wr1(12'h070, 24'h040506, 3'b110);
    push_wr(1, 12'h070, 24'h040506, 3'b110);
    push_wr(0, 12'h060, 24'h010203, 3'b111);
    cyc(); bus.scan_req = 1'b0;
    cyc(); bus.wr1_req  = 1'b0;
    cyc(); bus.wr0_req  = 1'b0;
    cyc();

    // Channel enables: partial write keeps green, empty-enable write changes nothing
    set_wr1(12'h005, 24'h112233, 3'b111);
    push_wr(1, 12'h005, 24'h112233, 3'b111);
    cyc(); bus.wr1_req = 1'b0;
    set_wr0(12'h005, 24'hA1B2C3, 3'b101);
    push_wr(0, 12'h005, 24'hA1B2C3, 3'b101);
    cyc(); bus.wr0_req = 1'b0;
    set_scan(12'h005);
    push_scan(12'h005, 1, 24'hA122C3);
    cyc(); bus.scan_req = 1'b0;
    set_wr1(12'h005, 24'hFFFFFF, 3'b000);
    push_wr(1, 12'h005, 24'hFFFFFF, 3'b000);
    cyc(); bus.wr1_req = 1'b0;
    set_scan(12'h005);
    push_scan(12'h005, 1, 24'hA122C3);
    cyc(); bus.scan_req = 1'b0;
    cyc();

    // Starvation on wr1: clear while still waiting loses, clear after ack wins
    set_wr1(12'h030, 24'h0F0F0F, 3'b111);
    for (int i = 0; i < 6; i++) begin
      set_scan(12'h005);
      push_scan(12'h005, 1, 24'hA122C3);
      bus.starve_clr = (i == 4);
      cyc();
      exp_starve = (i >= 3);
    end
    bus.scan_req   = 1'b0;
    bus.starve_clr = 1'b0;
    push_wr(1, 12'h030, 24'h0F0F0F, 3'b111);
    cyc(); bus.wr1_req = 1'b0; bus.starve_clr = 1'b1; exp_starve = 1'b1;
    cyc(); bus.starve_clr = 1'b0; exp_starve = 1'b0;
    cyc();

    // Reset one cycle after a scan grant: no read data, pending wr0 acked after release
    set_scan(12'h010);
    push_scan(12'h010, 0, 24'h0);
    set_wr0(12'h040, 24'h0C0C0C, 3'b111);
    cyc(); bus.scan_req = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    push_wr(0, 12'h040, 24'h0C0C0C, 3'b111);
    cyc(); bus.wr0_req = 1'b0;
    repeat (2) cyc();
    done = 1'b1;
  end

  // Monitor: compare memory port, read data and starve away from the clock edge
  always @(negedge clk) begin
    acc_t        got;
    acc_t        e;
    logic [23:0] d;
    got = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.wr1_ack, bus.wr0_ack};
    tests++;
    if (bus.mem_en) begin
      if (exp_acc.size() == 0) begin
        fails++;
        $display("FAIL access: unexpected access we=%0b addr=%h wdata=%h be=%b ack=%b at %0t",
                 got.we, got.addr, got.wdata, got.be, got.ack, $time);
      end else begin
        e = exp_acc.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL access: got we=%0b addr=%h wdata=%h be=%b ack=%b, want we=%0b addr=%h wdata=%h be=%b ack=%b at %0t",
                   got.we, got.addr, got.wdata, got.be, got.ack,
                   e.we, e.addr, e.wdata, e.be, e.ack, $time);
        end
      end
    end else if (got !== '0) begin
      fails++;
      $display("FAIL idle_port: got we=%0b addr=%h wdata=%h be=%b ack=%b, want all 0 at %0t",
               got.we, got.addr, got.wdata, got.be, got.ack, $time);
    end

    tests++;
    if (bus.scan_valid) begin
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL scan_valid: got 1 with data %h, want 0 at %0t", bus.scan_data, $time);
      end else begin
        d = exp_rd.pop_front();
        if (bus.scan_data !== d) begin
          fails++;
          $display("FAIL scan_data: got %h want %h at %0t", bus.scan_data, d, $time);
        end
      end
    end else if (bus.scan_data !== 24'h0) begin
      fails++;
      $display("FAIL scan_data_idle: got %h want 000000 at %0t", bus.scan_data, $time);
    end

    tests++;
    if (bus.starve !== exp_starve) begin
      fails++;
      $display("FAIL starve: got %0b want %0b at %0t", bus.starve, exp_starve, $time);
    end

    if (done) begin
      tests++;
      if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
        fails++;
        $display("FAIL drain: %0d accesses and %0d reads outstanding, want 0 and 0",
                 exp_acc.size(), exp_rd.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
